// File: rtl/wfr_sample_packer.sv
// Packs narrow ADC samples into LANES-wide words for the waveform recorder,
// collecting trigger lines and the lane-0 timestamp for each emitted word.
module wfr_sample_packer #(
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned LANES           = 8,
  parameter int unsigned TRIGGER_WIDTH   = 8,
  parameter int unsigned TIMESTAMP_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SAMPLE_WIDTH-1:0]          sampleData,
  input  logic                             sampleValid,
  input  logic                             align,
  input  logic [TRIGGER_WIDTH-1:0]         triggersIn,
  input  logic [TIMESTAMP_WIDTH-1:0]       timestampIn,
  output logic [LANES*SAMPLE_WIDTH-1:0]    outData,
  output logic                             outValid,
  output logic [TRIGGER_WIDTH-1:0]         outTriggers,
  output logic [$clog2(LANES)-1:0]         outTriggerLane,
  output logic [TIMESTAMP_WIDTH-1:0]       outTimestamp,
  output logic [31:0]                      wordCount
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned WORD_W = LANES * SAMPLE_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  initial begin : param_check
    assert (LANES >= 2 && LANES <= 16 && (LANES & (LANES - 1)) == 0)
      else $fatal(1, "LANES must be a power of two in 2..16");
  end

  logic [LANE_W-1:0]                     lane, lane_nxt;
  logic [LANES-1:0][SAMPLE_WIDTH-1:0]    partial, partial_nxt;
  logic [TIMESTAMP_WIDTH-1:0]            ts_hold, ts_hold_nxt;
  logic [TRIGGER_WIDTH-1:0]              acc, acc_nxt;
  logic [LANE_W-1:0]                     acc_lane, acc_lane_nxt;

  logic [WORD_W-1:0]                     out_data_nxt;
  logic                                  out_valid_nxt;
  logic [TRIGGER_WIDTH-1:0]              out_triggers_nxt;
  logic [LANE_W-1:0]                     out_trigger_lane_nxt;
  logic [TIMESTAMP_WIDTH-1:0]            out_timestamp_nxt;
  logic [31:0]                           word_count_nxt;

  logic [LANE_W-1:0]                     slot;
  logic [TRIGGER_WIDTH-1:0]              acc_base, acc_merged;
  logic [LANE_W-1:0]                     lane_base, lane_merged;

  // Next-state: align restarts the word, then the sample and triggers land in it.
  always_comb begin
    lane_nxt             = lane;
    partial_nxt          = partial;
    ts_hold_nxt          = ts_hold;
    acc_nxt              = acc;
    acc_lane_nxt         = acc_lane;
    out_data_nxt         = outData;
    out_valid_nxt        = 1'b0;
    out_triggers_nxt     = '0;
    out_trigger_lane_nxt = '0;
    out_timestamp_nxt    = outTimestamp;
    word_count_nxt       = wordCount;

    slot      = align ? '0 : lane;
    acc_base  = align ? '0 : acc;
    lane_base = align ? '0 : acc_lane;

    if (align) begin
      lane_nxt    = '0;
      partial_nxt = '0;
    end

    // First trigger of a word records the slot the current/next sample occupies.
    acc_merged  = acc_base | triggersIn;
    lane_merged = ((acc_base == '0) && (triggersIn != '0)) ? slot : lane_base;
    acc_nxt      = acc_merged;
    acc_lane_nxt = lane_merged;

    if (sampleValid) begin
      partial_nxt[slot] = sampleData;
      if (slot == '0) begin
        ts_hold_nxt = timestampIn;
      end
      if (slot == LAST_LANE) begin
        out_data_nxt         = partial_nxt;
        out_valid_nxt        = 1'b1;
        out_triggers_nxt     = acc_merged;
        out_trigger_lane_nxt = lane_merged;
        out_timestamp_nxt    = ts_hold;
        word_count_nxt       = wordCount + 32'd1;
        lane_nxt             = '0;
        acc_nxt              = '0;
        acc_lane_nxt         = '0;
      end else begin
        lane_nxt = slot + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane           <= '0;
      partial        <= '0;
      ts_hold        <= '0;
      acc            <= '0;
      acc_lane       <= '0;
      outData        <= '0;
      outValid       <= 1'b0;
      outTriggers    <= '0;
      outTriggerLane <= '0;
      outTimestamp   <= '0;
      wordCount      <= '0;
    end else begin
      lane           <= lane_nxt;
      partial        <= partial_nxt;
      ts_hold        <= ts_hold_nxt;
      acc            <= acc_nxt;
      acc_lane       <= acc_lane_nxt;
      outData        <= out_data_nxt;
      outValid       <= out_valid_nxt;
      outTriggers    <= out_triggers_nxt;
      outTriggerLane <= out_trigger_lane_nxt;
      outTimestamp   <= out_timestamp_nxt;
      wordCount      <= word_count_nxt;
    end
  end

endmodule

// File: tb/tb_wfr_sample_packer.sv
// Self-checking bench for wfr_sample_packer: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_wfr_sample_packer;

  localparam int unsigned SW = 16;
  localparam int unsigned LN = 8;
  localparam int unsigned TW = 8;
  localparam int unsigned TSW = 64;

  logic            clk;
  logic            reset;
  logic [SW-1:0]   sampleData;
  logic            sampleValid;
  logic            align;
  logic [TW-1:0]   triggersIn;
  logic [TSW-1:0]  timestampIn;
  logic [LN*SW-1:0] outData;
  logic            outValid;
  logic [TW-1:0]   outTriggers;
  logic [2:0]      outTriggerLane;
  logic [TSW-1:0]  outTimestamp;
  logic [31:0]     wordCount;

  wfr_sample_packer #(
    .SAMPLE_WIDTH(SW), .LANES(LN), .TRIGGER_WIDTH(TW), .TIMESTAMP_WIDTH(TSW)
  ) dut (
    .clk(clk), .reset(reset), .sampleData(sampleData), .sampleValid(sampleValid),
    .align(align), .triggersIn(triggersIn), .timestampIn(timestampIn),
    .outData(outData), .outValid(outValid), .outTriggers(outTriggers),
    .outTriggerLane(outTriggerLane), .outTimestamp(outTimestamp), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [TSW-1:0] ts_ctr = 64'h0000_1000_0000_0000;

  // Reference model: the word in progress is simply a queue of samples.
  logic [SW-1:0]    mq[$];
  logic [TSW-1:0]   m_ts_first;
  logic [TW-1:0]    m_acc;
  int               m_tl;
  logic [LN*SW-1:0] e_data;
  logic             e_valid;
  logic [TW-1:0]    e_trig;
  logic [2:0]       e_lane;
  logic [TSW-1:0]   e_ts;
  logic [31:0]      e_wc;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model(input logic r, input logic a, input logic v,
                       input logic [SW-1:0] d, input logic [TW-1:0] t, input logic [TSW-1:0] ts);
    if (r) begin
      mq.delete(); m_acc = '0; m_tl = 0;
      e_data = '0; e_valid = 0; e_trig = '0; e_lane = '0; e_ts = '0; e_wc = '0;
      return;
    end
    e_valid = 0; e_trig = '0; e_lane = '0;
    if (a) begin mq.delete(); m_acc = '0; m_tl = 0; end
    if (t != '0 && m_acc == '0) m_tl = mq.size();
    m_acc |= t;
    if (v) begin
      if (mq.size() == 0) m_ts_first = ts;
      mq.push_back(d);
      if (mq.size() == LN) begin
        for (int k = 0; k < LN; k++) e_data[k*SW +: SW] = mq[k];
        e_valid = 1; e_trig = m_acc; e_lane = 3'(m_tl); e_ts = m_ts_first;
        e_wc = e_wc + 32'd1;
        mq.delete(); m_acc = '0; m_tl = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output after the edge.
  task automatic step(input logic r, input logic a, input logic v,
                      input logic [SW-1:0] d, input logic [TW-1:0] t);
    reset = r; align = a; sampleValid = v; sampleData = d; triggersIn = t;
    timestampIn = ts_ctr;
    model(r, a, v, d, t, ts_ctr);
    @(posedge clk); #1;
    ts_ctr = ts_ctr + 64'd1;
    check("model_outValid", 256'(outValid), 256'(e_valid));
    check("model_outData", 256'(outData), 256'(e_data));
    check("model_outTriggers", 256'(outTriggers), 256'(e_trig));
    check("model_outTriggerLane", 256'(outTriggerLane), 256'(e_lane));
    check("model_outTimestamp", 256'(outTimestamp), 256'(e_ts));
    check("model_wordCount", 256'(wordCount), 256'(e_wc));
  endtask

  typedef struct {
    logic          sv;
    logic [SW-1:0] d;
    logic [TW-1:0] trig;
    logic          ev;
    logic [TW-1:0] etrig;
    logic [2:0]    elane;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic sv, input logic [SW-1:0] d, input logic [TW-1:0] t,
                         input logic ev, input logic [TW-1:0] et, input logic [2:0] el);
    vec_t v;
    v.sv = sv; v.d = d; v.trig = t; v.ev = ev; v.etrig = et; v.elane = el;
    vecs.push_back(v);
  endtask

  initial begin
    logic [LN*SW-1:0] exp_word;
    logic [TSW-1:0]   ts0;
    int strobes, last_strobe, wc0;

    clk = 0; reset = 1; align = 0; sampleValid = 0; sampleData = '0;
    triggersIn = '0; timestampIn = '0;

    // Trigger placement table, one row per cycle after reset.
    for (int i = 0; i < 8; i++)
      add_vec(1, 16'(16'h100 + i), (i == 3) ? 8'h01 : 8'h00, i == 7, (i == 7) ? 8'h01 : 8'h00, (i == 7) ? 3'd3 : 3'd0);
    for (int i = 0; i < 6; i++) add_vec(1, 16'(16'h200 + i), 8'h00, 0, 8'h00, 3'd0);
    add_vec(0, 16'h0, 8'h10, 0, 8'h00, 3'd0);
    add_vec(1, 16'h206, 8'h00, 0, 8'h00, 3'd0);
    add_vec(1, 16'h207, 8'h00, 1, 8'h10, 3'd6);
    add_vec(0, 16'h0, 8'h02, 0, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++)
      add_vec(1, 16'(16'h300 + i), 8'h00, i == 7, (i == 7) ? 8'h02 : 8'h00, 3'd0);
    for (int i = 0; i < 8; i++)
      add_vec(1, 16'(16'h400 + i), (i == 2) ? 8'h01 : ((i == 6) ? 8'h80 : 8'h00),
              i == 7, (i == 7) ? 8'h81 : 8'h00, (i == 7) ? 3'd2 : 3'd0);
    for (int i = 0; i < 8; i++)
      add_vec(1, 16'(16'h500 + i), (i == 7) ? 8'h04 : 8'h00, i == 7, (i == 7) ? 8'h04 : 8'h00, (i == 7) ? 3'd7 : 3'd0);

    step(1, 0, 0, '0, '0);
    check("reset_outValid", 256'(outValid), 256'(0));
    check("reset_outData", 256'(outData), 256'(0));
    check("reset_wordCount", 256'(wordCount), 256'(0));

    foreach (vecs[i]) begin
      step(0, 0, vecs[i].sv, vecs[i].d, vecs[i].trig);
      check($sformatf("vec%0d_outValid", i), 256'(outValid), 256'(vecs[i].ev));
      check($sformatf("vec%0d_outTriggers", i), 256'(outTriggers), 256'(vecs[i].etrig));
      check($sformatf("vec%0d_outTriggerLane", i), 256'(outTriggerLane), 256'(vecs[i].elane));
    end

    // Basic packing with sparse samples.
    step(1, 0, 0, '0, '0);
    strobes = 0; ts0 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) ts0 = ts_ctr;
      step(0, 0, 1, 16'(i), '0);
      if (outValid) strobes++;
      if (i < 7) for (int j = 0; j < 15; j++) begin
        step(0, 0, 0, '0, '0);
        if (outValid) strobes++;
      end
    end
    exp_word = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    check("basic_outValid", 256'(outValid), 256'(1));
    check("basic_strobes", 256'(strobes), 256'(1));
    check("basic_outData", 256'(outData), 256'(exp_word));
    check("basic_outTimestamp", 256'(outTimestamp), 256'(ts0));
    check("basic_wordCount", 256'(wordCount), 256'(1));
    step(0, 0, 0, '0, '0);
    check("basic_strobe_one_cycle", 256'(outValid), 256'(0));
    check("basic_data_held", 256'(outData), 256'(exp_word));

    // Back-to-back stream: strobes exactly LANES cycles apart.
    strobes = 0; last_strobe = -1;
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, 16'(16'h1000 + i), '0);
      if (outValid) begin
        if (last_strobe >= 0) check("b2b_spacing", 256'(i - last_strobe), 256'(LN));
        last_strobe = i;
        strobes++;
      end
    end
    check("b2b_strobes", 256'(strobes), 256'(8));
    for (int k = 0; k < LN; k++) exp_word[k*SW +: SW] = 16'(16'h1000 + 56 + k);
    check("b2b_last_word", 256'(outData), 256'(exp_word));

    // Align after 5 samples discards them.
    wc0 = int'(wordCount); strobes = 0;
    for (int i = 0; i < 5; i++) begin step(0, 0, 1, 16'h0EE, '0); if (outValid) strobes++; end
    step(0, 1, 0, '0, '0); if (outValid) strobes++;
    for (int i = 0; i < 8; i++) begin step(0, 0, 1, 16'(16'hA0 + i), '0); if (outValid) strobes++; end
    for (int k = 0; k < LN; k++) exp_word[k*SW +: SW] = 16'(16'hA0 + k);
    check("align_strobes", 256'(strobes), 256'(1));
    check("align_outData", 256'(outData), 256'(exp_word));
    check("align_wordCount", 256'(wordCount), 256'(wc0 + 1));

    // Align with a sample and trigger on the same cycle starts a new word at lane 0.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0DD, '0);
    step(0, 1, 1, 16'hB0, 8'h08);
    for (int i = 1; i < 8; i++) step(0, 0, 1, 16'(16'hB0 + i), '0);
    check("align_sv_outTriggers", 256'(outTriggers), 256'(8'h08));
    check("align_sv_outTriggerLane", 256'(outTriggerLane), 256'(0));

    // Align on the completing cycle wins.
    for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h0CC, '0);
    step(0, 1, 1, 16'h0C0, '0);
    check("align_complete_no_strobe", 256'(outValid), 256'(0));

    // Reset mid-word with a trigger pending.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0BB, (i == 2) ? 8'h20 : 8'h00);
    step(1, 1, 1, 16'h0BB, 8'h40);
    check("rst_mid_outData", 256'(outData), 256'(0));
    check("rst_mid_outTimestamp", 256'(outTimestamp), 256'(0));
    check("rst_mid_wordCount", 256'(wordCount), 256'(0));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 16'(16'hC0 + i), '0);
    check("rst_mid_outValid", 256'(outValid), 256'(1));
    check("rst_mid_outTriggers", 256'(outTriggers), 256'(0));
    for (int k = 0; k < LN; k++) exp_word[k*SW +: SW] = 16'(16'hC0 + k);
    check("rst_mid_word", 256'(outData), 256'(exp_word));

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 16'($urandom),
           ($urandom_range(0, 6) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
